// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer/address geometry and Gray-code helpers.
// Both the read-side and write-side pointer blocks import this package so the
// two domains always agree on widths and encoding.
package fifo_pkg;

    localparam int ADDR_WIDTH = 3;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;  // MSB is the wrap bit
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    // Standard reflected Gray code: adjacent values differ in exactly one bit.
    function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Inverse of bin2gray: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] gray);
        logic [PTR_WIDTH-1:0] bin;
        bin[PTR_WIDTH-1] = gray[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: synchronised write pointer and memory read
// port on one side, first-word-fall-through consumer handshake on the other.
//
// Handshake: a word transfers on every clk edge where out_valid && out_ready.
// Once out_valid is high it stays high, and out_data stays stable, until that
// transfer happens. out_ready may be asserted freely; with out_valid low it has
// no effect.
interface fifo_rd_ctrl_if;
    import fifo_pkg::*;

    logic [PTR_WIDTH-1:0]  rq2_wptr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [PTR_WIDTH-1:0]  rptr;
    logic                  rempty;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic [PTR_WIDTH-1:0]  rlevel;

    // The read controller side.
    modport slave (
        input  rq2_wptr, mem_rdata, out_ready,
        output raddr, rptr, rempty, out_data, out_valid, rlevel
    );

    // The environment: write-domain sync, memory and consumer.
    modport master (
        output rq2_wptr, mem_rdata, out_ready,
        input  raddr, rptr, rempty, out_data, out_valid, rlevel
    );

endinterface

// File: rtl/fifo_rd_out_reg.sv
// First-word-fall-through output register. Holds the head word for the
// consumer and tells the pointer logic when it can take another word.
module fifo_rd_out_reg
    import fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,        // asynchronous, active-low
    input  logic                  fetch,      // load mem_rdata this edge
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  out_ready,
    output logic                  can_accept, // register empty or being drained
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;

    // A fetch may replace the head in the same edge that it is consumed,
    // which is what allows one word per clock while data is available.
    assign can_accept = !out_valid_q || out_ready;

    // Next head word: load on fetch, drop valid on a plain transfer, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (fetch) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_rdata;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Head word register; reset drops any word it held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO. Keeps the binary and Gray read
// pointers, the empty flag and the fill level against the synchronised write
// pointer, and prefetches memory words into a FWFT output register.
// The empty flag is pessimistic: rq2_wptr lags the real write pointer, so
// empty can only clear late, never early.
module fifo_rd_ctrl
    import fifo_pkg::*;
(
    input  logic           clk,
    input  logic           rst,   // asynchronous, active-low
    fifo_rd_ctrl_if.slave  bus
);

    logic [PTR_WIDTH-1:0] rbin_q,   rbin_d;
    logic [PTR_WIDTH-1:0] rptr_q,   rptr_d;
    logic                 rempty_q, rempty_d;
    logic [PTR_WIDTH-1:0] rlevel_q, rlevel_d;
    logic                 fetch;
    logic                 can_accept;

    // Pointer, empty and level next-state; all three look at the pointer
    // after this cycle's fetch so they are consistent on the same edge.
    // The level counts only words still in memory, not the head word.
    always_comb begin
        fetch    = !rempty_q && can_accept;
        rbin_d   = rbin_q + PTR_WIDTH'(fetch);
        rptr_d   = bin2gray(rbin_d);
        rempty_d = (rptr_d == bus.rq2_wptr);
        rlevel_d = gray2bin(bus.rq2_wptr) - rbin_d;
    end

    // Read pointer, empty flag and level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
            rlevel_q <= rlevel_d;
        end
    end

    fifo_rd_out_reg u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .fetch      (fetch),
        .mem_rdata  (bus.mem_rdata),
        .out_ready  (bus.out_ready),
        .can_accept (can_accept),
        .out_data   (bus.out_data),
        .out_valid  (bus.out_valid)
    );

    assign bus.raddr  = rbin_q[ADDR_WIDTH-1:0];
    assign bus.rptr   = rptr_q;
    assign bus.rempty = rempty_q;
    assign bus.rlevel = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for the async-FIFO read controller.
module tb_fifo_rd_ctrl;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_ctrl_if bus();

    fifo_rd_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural FIFO memory, combinational read at the DUT's address.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    assign bus.mem_rdata = mem[bus.raddr];

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    logic [DATA_WIDTH-1:0] exp_q[$];

    // Reference model: word counts as plain integers.
    int       w_cnt   = 0;     // words made visible via rq2_wptr
    int       m_rd    = 0;     // words taken out of memory
    bit       m_valid = 1'b0;
    bit       m_empty = 1'b1;
    logic [3:0] m_level = '0;
    bit       wr_done = 1'b0;

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ {1'b0, b[3:1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write one word into free memory and publish the new write pointer.
    task automatic wr(input logic [DATA_WIDTH-1:0] d);
        int t;
        t = 0;
        while ((w_cnt - m_rd) >= DEPTH && t < 200) begin
            cyc(1);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_timeout: got no space expected space at %0t", $time);
        end
        mem[3'(w_cnt)] = d;
        exp_q.push_back(d);
        w_cnt++;
        bus.rq2_wptr = gray4(w_cnt);
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_rptr",      32'(bus.rptr),      32'h0);
        chk("rst_rempty",    32'(bus.rempty),    32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_rlevel",    32'(bus.rlevel),    32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        m_rd    = 0;
        w_cnt   = 0;
        m_valid = 1'b0;
        m_empty = 1'b1;
        m_level = '0;
        exp_q.delete();
        bus.rq2_wptr = '0;
        cyc(2);
        rst = 1'b1;
    endtask

    // Reference model update on each edge.
    always @(posedge clk) begin
        bit f;
        if (rst) begin
            f = !m_empty && (!m_valid || bus.out_ready);
            if (f) begin
                m_rd++;
                m_valid = 1'b1;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            m_level = 4'(w_cnt - m_rd);
            m_empty = (m_level == 4'd0);
        end
    end

    // Monitor: compare control outputs to the model, pop words on transfer,
    // and check the head is stable under backpressure.
    bit                    prev_hold = 1'b0;
    logic [DATA_WIDTH-1:0] prev_data;
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("rempty",    32'(bus.rempty),    32'(m_empty));
            chk("rlevel",    32'(bus.rlevel),    32'(m_level));
            chk("rptr",      32'(bus.rptr),      32'(gray4(m_rd)));
            chk("raddr",     32'(bus.raddr),     32'(m_rd % DEPTH));
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'h1);
                chk("hold_data",  32'(bus.out_data),  32'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                    n_rx++;
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int rx0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.out_ready = 1'b0;
        bus.rq2_wptr  = '0;
        do_reset();

        // Single word with consumer stalled.
        cyc(1);
        wr(8'hA5);
        cyc(1);
        chk("single_rempty",  32'(bus.rempty),    32'h0);
        chk("single_valid_0", 32'(bus.out_valid), 32'h0);
        cyc(1);
        chk("single_valid_1", 32'(bus.out_valid), 32'h1);
        chk("single_data",    32'(bus.out_data),  32'hA5);
        chk("single_rptr",    32'(bus.rptr),      32'h1);
        cyc(3);
        chk("single_held_v",  32'(bus.out_valid), 32'h1);
        chk("single_held_d",  32'(bus.out_data),  32'hA5);

        // Reset mid-stream while a word is held.
        do_reset();

        // Streaming five words back to back.
        cyc(1);
        bus.out_ready = 1'b1;
        rx0 = n_rx;
        for (int i = 0; i < 5; i++) wr(8'($urandom));
        cyc(1);
        chk("stream_lat_valid", 32'(bus.out_valid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stream_valid", 32'(bus.out_valid), 32'h1);
        end
        cyc(1);
        chk("stream_end_valid",  32'(bus.out_valid), 32'h0);
        chk("stream_end_rempty", 32'(bus.rempty),    32'h1);
        chk("stream_end_rptr",   32'(bus.rptr),      32'h7);
        chk("stream_count",      32'(n_rx - rx0),    32'd5);

        // Advance to rbin=14, then wrap through 15 -> 0.
        for (int i = 0; i < 9; i++) wr(8'($urandom));
        cyc(20);
        chk("prewrap_rptr", 32'(bus.rptr), 32'h9);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'($urandom));
        chk("wrap_wptr", 32'(bus.rq2_wptr), 32'h3);
        cyc(1);
        chk("wrap_rlevel", 32'(bus.rlevel), 32'd4);
        chk("wrap_rempty", 32'(bus.rempty), 32'h0);
        bus.out_ready = 1'b1;
        chk("wrap_raddr0", 32'(bus.raddr), 32'd6);
        cyc(1);
        chk("wrap_raddr1", 32'(bus.raddr), 32'd7);
        cyc(1);
        chk("wrap_raddr2", 32'(bus.raddr), 32'd0);
        cyc(1);
        chk("wrap_raddr3", 32'(bus.raddr), 32'd1);
        cyc(5);
        chk("wrap_end_rptr",   32'(bus.rptr),   32'h3);
        chk("wrap_end_rempty", 32'(bus.rempty), 32'h1);

        // Full-level view: rbin=3 with the head held, then 8 more words.
        do_reset();
        bus.out_ready = 1'b0;
        cyc(1);
        wr(8'($urandom));
        cyc(3);
        wr(8'($urandom));
        wr(8'($urandom));
        cyc(2);
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        cyc(1);
        chk("full_pre_rptr",   32'(bus.rptr),      32'h2);
        chk("full_pre_rempty", 32'(bus.rempty),    32'h1);
        chk("full_pre_valid",  32'(bus.out_valid), 32'h1);
        for (int i = 0; i < 8; i++) wr(8'($urandom));
        chk("full_wptr", 32'(bus.rq2_wptr), 32'hE);
        cyc(1);
        chk("full_rlevel", 32'(bus.rlevel), 32'd8);
        chk("full_rempty", 32'(bus.rempty), 32'h0);
        cyc(2);
        chk("full_rlevel_held", 32'(bus.rlevel), 32'd8);

        // Random backpressure with 20 words.
        do_reset();
        cyc(1);
        rx0 = n_rx;
        wr_done = 1'b0;
        fork
            begin : writer
                for (int i = 0; i < 20; i++) begin
                    cyc($urandom_range(0, 3));
                    wr(8'($urandom));
                end
                wr_done = 1'b1;
            end
            begin : consumer
                int t;
                t = 0;
                while ((!wr_done || exp_q.size() != 0) && t < 3000) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    cyc(1);
                    t++;
                end
                if (t >= 3000) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bp_drain: got %0d left expected 0", exp_q.size());
                end
            end
        join
        bus.out_ready = 1'b1;
        cyc(3);
        chk("bp_count",  32'(n_rx - rx0),     32'd20);
        chk("bp_queue",  32'(exp_q.size()),   32'd0);
        chk("bp_rempty", 32'(bus.rempty),     32'h1);
        chk("bp_valid",  32'(bus.out_valid),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
